// File: rtl/branch_resolution_tracker.sv
// ----------------------------------------------------------------------------
// branch_resolution_tracker
//
// Writer side of the global-history predictor's update interface.
// Every conditional branch issued by fetch is queued with its prediction and
// both candidate next PCs. When a branch resolves in WB, the oldest entry is
// popped. One cycle later the predictor update strobe, the resolved PC and the
// outcome are driven. A wrong prediction empties the queue, because every
// younger entry is on the wrong path. It also raises a one-cycle
// flush/redirect to fetch.
//
// Optional feature macro: BRANCH_STATS_EN
//   When defined, the module adds the saturating counters branch_count and
//   mispredict_count.
//
// Parameters
//   DEPTH  in-flight branch entries (power of 2, >= 2)
//   CNT_W  statistics counter width (BRANCH_STATS_EN only)
//
// Ports
//   clk                    clock
//   reset                  synchronous active-high reset
//   fetch_push             fetch issued a conditional branch this cycle
//   fetch_pc               PC of that branch
//   fetch_predict_taken    prediction used by fetch
//   fetch_target_pc        taken-path PC
//   fetch_fallthrough_pc   not-taken PC
//   full                   queue holds DEPTH entries; fetch must stall branches
//   empty                  queue holds no entries
//   wb_branch_valid        a conditional branch resolves in WB this cycle
//   wb_take_jump           actual outcome of that branch
//   update_branch_history  1-cycle update strobe to the predictor
//   resolved_pc            PC of the resolved branch
//   resolved_taken         outcome forwarded to the predictor
//   mispredict             1-cycle flush request to the pipeline
//   redirect_pc            correct-path PC, valid while mispredict=1
//   underflow_err          sticky: a resolve arrived while the queue was empty
//   branch_count           (BRANCH_STATS_EN) accepted resolves, saturating
//   mispredict_count       (BRANCH_STATS_EN) mispredicts, saturating
// ----------------------------------------------------------------------------
module branch_resolution_tracker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_push,
  input  logic [15:0]      fetch_pc,
  input  logic             fetch_predict_taken,
  input  logic [15:0]      fetch_target_pc,
  input  logic [15:0]      fetch_fallthrough_pc,
  output logic             full,
  output logic             empty,
  input  logic             wb_branch_valid,
  input  logic             wb_take_jump,
  output logic             update_branch_history,
  output logic [15:0]      resolved_pc,
  output logic             resolved_taken,
  output logic             mispredict,
  output logic [15:0]      redirect_pc,
  output logic             underflow_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);
  localparam logic [CNT_FW-1:0] FULL_COUNT = CNT_FW'(DEPTH);

  typedef struct packed {
    logic [15:0] pc;
    logic        pred;
    logic [15:0] target;
    logic [15:0] fallthrough;
  } entry_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_FW-1:0]  count_reg;
  logic               update_reg;
  logic [15:0]        resolved_pc_reg;
  logic               resolved_taken_reg;
  logic               mispredict_reg;
  logic [15:0]        redirect_pc_reg;
  logic               underflow_reg;

  entry_t             entries [DEPTH];
  entry_t             head;
  entry_t             new_entry;

  logic               in_run;
  logic               resolve_ok;
  logic               mispredict_now;
  logic               push_ok;
  logic               underflow_now;

  assign new_entry = '{pc:          fetch_pc,
                       pred:        fetch_predict_taken,
                       target:      fetch_target_pc,
                       fallthrough: fetch_fallthrough_pc};

  assign head = entries[rd_ptr_reg];

  // Event decode. FLUSH suppresses everything, because both the push and the
  // resolve are wrong-path work in that cycle.
  always_comb begin
    in_run         = (state_reg == ST_RUN);
    resolve_ok     = in_run && wb_branch_valid && (count_reg != '0);
    mispredict_now = resolve_ok && (head.pred != wb_take_jump);
    underflow_now  = in_run && wb_branch_valid && (count_reg == '0);
    // A full queue still accepts a push when the same edge frees the head slot.
    // A push in the same cycle as a mispredict is on the wrong path and is dropped.
    push_ok        = in_run && fetch_push && !mispredict_now &&
                     ((count_reg != FULL_COUNT) || resolve_ok);
  end

  // Entry storage: one register slot per entry, written when it is the tail.
  // When the queue is full and a push coincides with a pop, the tail and the
  // head are the same slot. The head is read before the edge, so the old
  // contents still reach the outputs.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_t slot_reg;
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_reg <= new_entry;
        end
      end
      assign entries[gi] = slot_reg;
    end
  endgenerate

  // Control FSM, queue pointers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= ST_RUN;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
      update_reg         <= 1'b0;
      resolved_pc_reg    <= 16'h0;
      resolved_taken_reg <= 1'b0;
      mispredict_reg     <= 1'b0;
      redirect_pc_reg    <= 16'h0;
      underflow_reg      <= 1'b0;
    end else begin
      update_reg     <= 1'b0;
      mispredict_reg <= 1'b0;
      case (state_reg)
        ST_RUN: begin
          if (underflow_now) begin
            underflow_reg <= 1'b1;
          end
          if (resolve_ok) begin
            update_reg         <= 1'b1;
            resolved_pc_reg    <= head.pc;
            resolved_taken_reg <= wb_take_jump;
          end
          if (mispredict_now) begin
            mispredict_reg  <= 1'b1;
            redirect_pc_reg <= wb_take_jump ? head.target : head.fallthrough;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            state_reg       <= ST_FLUSH;
          end else begin
            if (push_ok) begin
              wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (resolve_ok) begin
              rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, resolve_ok})
              2'b10:   count_reg <= count_reg + CNT_FW'(1);
              2'b01:   count_reg <= count_reg - CNT_FW'(1);
              default: count_reg <= count_reg;
            endcase
          end
        end
        ST_FLUSH: begin
          state_reg <= ST_RUN;
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  assign full                  = (count_reg == FULL_COUNT);
  assign empty                 = (count_reg == '0);
  assign update_branch_history = update_reg;
  assign resolved_pc           = resolved_pc_reg;
  assign resolved_taken        = resolved_taken_reg;
  assign mispredict            = mispredict_reg;
  assign redirect_pc           = redirect_pc_reg;
  assign underflow_err         = underflow_reg;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_count_reg;
  logic [CNT_W-1:0] mispredict_count_reg;

  // Saturating counters: both stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (resolve_ok && (branch_count_reg != '1)) begin
        branch_count_reg <= branch_count_reg + CNT_W'(1);
      end
      if (mispredict_now && (mispredict_count_reg != '1)) begin
        mispredict_count_reg <= mispredict_count_reg + CNT_W'(1);
      end
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;
`endif

endmodule

// File: tb/tb_branch_resolution_tracker.sv
// ----------------------------------------------------------------------------
// Testbench for branch_resolution_tracker.
// The driver applies inputs on the falling edge. It advances a queue-based
// reference model and pushes the expected responses into scoreboard queues,
// each tagged with the rising edge that should present them. A separate
// monitor samples the DUT shortly after every rising edge and consumes those
// queues.
// ----------------------------------------------------------------------------
module tb_branch_resolution_tracker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_push = 1'b0;
  logic [15:0] fetch_pc = 16'h0;
  logic        fetch_predict_taken = 1'b0;
  logic [15:0] fetch_target_pc = 16'h0;
  logic [15:0] fetch_fallthrough_pc = 16'h0;
  logic        full;
  logic        empty;
  logic        wb_branch_valid = 1'b0;
  logic        wb_take_jump = 1'b0;
  logic        update_branch_history;
  logic [15:0] resolved_pc;
  logic        resolved_taken;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic        underflow_err;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
`endif

  branch_resolution_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .fetch_push           (fetch_push),
    .fetch_pc             (fetch_pc),
    .fetch_predict_taken  (fetch_predict_taken),
    .fetch_target_pc      (fetch_target_pc),
    .fetch_fallthrough_pc (fetch_fallthrough_pc),
    .full                 (full),
    .empty                (empty),
    .wb_branch_valid      (wb_branch_valid),
    .wb_take_jump         (wb_take_jump),
    .update_branch_history(update_branch_history),
    .resolved_pc          (resolved_pc),
    .resolved_taken       (resolved_taken),
    .mispredict           (mispredict),
    .redirect_pc          (redirect_pc),
    .underflow_err        (underflow_err)
`ifdef BRANCH_STATS_EN
    ,
    .branch_count         (branch_count),
    .mispredict_count     (mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    logic [15:0] pc;
    logic        pred;
    logic [15:0] tgt;
    logic [15:0] ft;
  } ent_t;
  typedef struct { int cyc; logic [15:0] pc; logic taken; } upd_t;
  typedef struct { int cyc; logic [15:0] pc; } mis_t;
  typedef struct { int cyc; bit full; bit empty; bit uf; bit zero; int bc; int mc; } st_t;

  // Reference model state
  ent_t mq[$];
  bit   m_flush = 0;
  bit   m_uf = 0;
  int   m_bc = 0;
  int   m_mc = 0;

  // Scoreboard queues
  upd_t upd_q[$];
  mis_t mis_q[$];
  st_t  st_q[$];

  int n_vec = 0;
  int n_mis = 0;

  task automatic check_val(string name, longint act, longint exp, int cyc);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus plus the reference-model step for it.
  task automatic step(bit r, bit push, logic [15:0] pc, bit pred, logic [15:0] tgt,
                      logic [15:0] ft, bit wbv, bit take);
    int   k;
    ent_t e;
    ent_t h;
    st_t  s;
    @(negedge clk);
    reset                = r;
    fetch_push           = push;
    fetch_pc             = pc;
    fetch_predict_taken  = pred;
    fetch_target_pc      = tgt;
    fetch_fallthrough_pc = ft;
    wb_branch_valid      = wbv;
    wb_take_jump         = take;
    k = edge_no + 1;
    e = '{pc: pc, pred: pred, tgt: tgt, ft: ft};
    if (r) begin
      mq.delete();
      m_flush = 0; m_uf = 0; m_bc = 0; m_mc = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (wbv && mq.size() > 0) begin
      h = mq.pop_front();
      upd_q.push_back('{cyc: k, pc: h.pc, taken: take});
      if (m_bc < (1 << CNT_W) - 1) m_bc++;
      if (h.pred != take) begin
        mis_q.push_back('{cyc: k, pc: take ? h.tgt : h.ft});
        if (m_mc < (1 << CNT_W) - 1) m_mc++;
        mq.delete();
        m_flush = 1;
      end else if (push) begin
        mq.push_back(e);
      end
    end else begin
      if (wbv) m_uf = 1;
      if (push && mq.size() < DEPTH) mq.push_back(e);
    end
    s = '{cyc: k, full: (mq.size() == DEPTH), empty: (mq.size() == 0),
          uf: m_uf, zero: r, bc: m_bc, mc: m_mc};
    st_q.push_back(s);
    $display("txn edge=%0d rst=%0b push=%0b pc=%h pred=%0b wbv=%0b take=%0b depth=%0d",
             k, r, push, pc, pred, wbv, take, mq.size());
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
  endtask

  task automatic push_br(logic [15:0] pc, bit pred, logic [15:0] tgt);
    step(0, 1, pc, pred, tgt, pc + 16'd2, 0, 0);
  endtask

  task automatic resolve(bit take);
    step(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, take);
  endtask

  // Monitor: consumes the scoreboard whenever the DUT presents a response
  initial begin : monitor
    upd_t u;
    mis_t m;
    st_t  s;
    int   n;
    forever begin
      @(posedge clk);
      #2;
      n = edge_no;
      if (update_branch_history === 1'b1) begin
        if (upd_q.size() == 0) begin
          check_val("upd_unexpected", 1, 0, n);
        end else begin
          u = upd_q.pop_front();
          check_val("upd_edge", n, u.cyc, n);
          check_val("resolved_pc", resolved_pc, u.pc, n);
          check_val("resolved_taken", resolved_taken, u.taken, n);
        end
      end else if (upd_q.size() > 0 && upd_q[0].cyc <= n) begin
        u = upd_q.pop_front();
        check_val("upd_missing", update_branch_history, 1, n);
      end
      if (mispredict === 1'b1) begin
        if (mis_q.size() == 0) begin
          check_val("mis_unexpected", 1, 0, n);
        end else begin
          m = mis_q.pop_front();
          check_val("mis_edge", n, m.cyc, n);
          check_val("redirect_pc", redirect_pc, m.pc, n);
        end
      end else if (mis_q.size() > 0 && mis_q[0].cyc <= n) begin
        m = mis_q.pop_front();
        check_val("mis_missing", mispredict, 1, n);
      end
      while (st_q.size() > 0 && st_q[0].cyc < n) void'(st_q.pop_front());
      if (st_q.size() > 0 && st_q[0].cyc == n) begin
        s = st_q.pop_front();
        check_val("full", full, s.full, n);
        check_val("empty", empty, s.empty, n);
        check_val("underflow_err", underflow_err, s.uf, n);
        if (s.zero) begin
          check_val("rst_resolved_pc", resolved_pc, 0, n);
          check_val("rst_redirect_pc", redirect_pc, 0, n);
          check_val("rst_resolved_taken", resolved_taken, 0, n);
          check_val("rst_update", update_branch_history, 0, n);
          check_val("rst_mispredict", mispredict, 0, n);
        end
`ifdef BRANCH_STATS_EN
        check_val("branch_count", branch_count, s.bc, n);
        check_val("mispredict_count", mispredict_count, s.mc, n);
`endif
      end
    end
  end

  initial begin : driver
    bit          r;
    bit          push;
    bit          pred;
    bit          wbv;
    bit          take;
    logic [15:0] pc;
    logic [15:0] tgt;

    // 1: correctly predicted taken branch
    step(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
    push_br(16'h3000, 1, 16'h3010);
    resolve(1);
    idle();

    // 2: mispredict, then a push during the flush cycle is dropped
    push_br(16'h3000, 0, 16'h3020);
    resolve(1);
    push_br(16'h4000, 1, 16'h4010);
    idle();
    resolve(0);  // queue must be empty here, so this is an underflow
    step(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0);

    // 3: fill, drop the fifth push, drain in order
    push_br(16'h1000, 1, 16'h1100);
    push_br(16'h1002, 0, 16'h1200);
    push_br(16'h1004, 1, 16'h1300);
    push_br(16'h1006, 0, 16'h1400);
    push_br(16'h1008, 1, 16'h1500);
    resolve(1);
    resolve(0);
    resolve(1);
    resolve(0);
    idle();

    // 4: full queue, push and resolve in the same cycle
    push_br(16'h2000, 0, 16'h2100);
    push_br(16'h2002, 1, 16'h2200);
    push_br(16'h2004, 0, 16'h2300);
    push_br(16'h2006, 1, 16'h2400);
    step(0, 1, 16'h5000, 1, 16'h5100, 16'h5002, 1, 0);
    resolve(1);
    resolve(0);
    resolve(1);
    resolve(1);
    idle();

    // 5: resolve while empty, including a same-cycle push
    resolve(1);
    step(0, 1, 16'h6000, 1, 16'h6100, 16'h6002, 1, 1);
    resolve(1);
    idle();

    // 6: reset with entries in flight
    push_br(16'h7000, 1, 16'h7100);
    push_br(16'h7002, 1, 16'h7200);
    push_br(16'h7004, 1, 16'h7300);
    step(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 99) == 0);
      push = ($urandom_range(0, 99) < 55);
      pc   = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      tgt  = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      pred = 1'($urandom_range(0, 1));
      wbv  = ($urandom_range(0, 99) < 45);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) take = mq[0].pred;
      else take = 1'($urandom_range(0, 1));
      step(r, push, pc, pred, tgt, pc + 16'd2, wbv, take);
    end

    idle();
    idle();
    idle();
    @(posedge clk);
    #4;
    check_val("drain_upd_q", upd_q.size(), 0, edge_no);
    check_val("drain_mis_q", mis_q.size(), 0, edge_no);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
